// File: rtl/qei_array_pkg.sv
// Shared definitions for the multi-channel quadrature encoder interface:
// step codes produced by the 4x decoder and the decode function itself.
package qei_array_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Decode a filtered {A,B} transition into a step code.
    // Forward sequence is 00 -> 10 -> 11 -> 01 -> 00; both bits moving is illegal.
    function automatic step_e qei_decode(input logic [1:0] prev, input logic [1:0] curr);
        step_e s;
        s = STEP_NONE;
        case ({prev, curr})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_INC;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: s = STEP_DEC;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ERR;
            default:                                s = STEP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/qei_array_chan.sv
// One encoder channel: synchroniser, glitch filter, priming, 4x decode,
// wrapping position counter, saturating velocity accumulator, dir/err flags.
import qei_array_pkg::*;

module qei_array_chan #(
    parameter int NBITS       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int VBITS       = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    a,
    input  logic                    b,
    input  logic                    err_clr,
    input  logic                    win_last,
    output logic [NBITS-1:0]        cnt_next,
    output logic [NBITS-1:0]        cnt,
    output logic signed [VBITS-1:0] vel,
    output logic                    dir,
    output logic                    err
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0] RUN_LAST = FW'(FILT_LEN - 1);
    localparam logic [FW-1:0] RUN_ONE  = FW'(1);
    localparam logic [NBITS-1:0] CNT_ONE = NBITS'(1);
    localparam logic signed [VBITS-1:0] VEL_ONE = VBITS'(1);
    localparam logic signed [VBITS-1:0] VEL_MAX = {1'b0, {(VBITS-1){1'b1}}};
    localparam logic signed [VBITS-1:0] VEL_MIN = {1'b1, {(VBITS-2){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_a_r, sync_b_r;
    logic                   filt_a_r, filt_b_r;
    logic [FW-1:0]          run_a_r, run_b_r, prime_run_r;
    logic                   primed_r;
    logic [1:0]             state_r;
    logic [1:0]             synced_s, filt_s;
    step_e                  step_s;
    logic [NBITS-1:0]       cnt_r, cnt_next_s;
    logic signed [VBITS-1:0] acc_r, acc_next_s, vel_r;
    logic                   dir_r, err_r;

    assign synced_s = {sync_a_r[SYNC_STAGES-1], sync_b_r[SYNC_STAGES-1]};
    assign filt_s   = {filt_a_r, filt_b_r};

    // Bring the asynchronous encoder pins into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_r <= '0;
            sync_b_r <= '0;
        end else begin
            sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], a};
            sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], b};
        end
    end

    // Before priming the filtered pair follows the synced pair and waits for it to
    // hold steady; afterwards each bit only moves after FILT_LEN clocks of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_a_r    <= 1'b0;
            filt_b_r    <= 1'b0;
            run_a_r     <= '0;
            run_b_r     <= '0;
            prime_run_r <= '0;
            primed_r    <= 1'b0;
        end else if (!primed_r) begin
            run_a_r <= '0;
            run_b_r <= '0;
            if (filt_s != synced_s) begin
                filt_a_r    <= synced_s[1];
                filt_b_r    <= synced_s[0];
                prime_run_r <= '0;
            end else if (prime_run_r == RUN_LAST) begin
                primed_r    <= 1'b1;
            end else begin
                prime_run_r <= prime_run_r + RUN_ONE;
            end
        end else begin
            if (synced_s[1] == filt_a_r) begin
                run_a_r  <= '0;
            end else if (run_a_r == RUN_LAST) begin
                filt_a_r <= synced_s[1];
                run_a_r  <= '0;
            end else begin
                run_a_r  <= run_a_r + RUN_ONE;
            end
            if (synced_s[0] == filt_b_r) begin
                run_b_r  <= '0;
            end else if (run_b_r == RUN_LAST) begin
                filt_b_r <= synced_s[0];
                run_b_r  <= '0;
            end else begin
                run_b_r  <= run_b_r + RUN_ONE;
            end
        end
    end

    // Decode the filtered transition; nothing is reported until the channel is primed.
    always_comb begin
        step_s = STEP_NONE;
        if (primed_r) begin
            step_s = qei_decode(state_r, filt_s);
        end else begin
            step_s = STEP_NONE;
        end
    end

    // Next position: clear wins over a step, en=0 freezes the count.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = '0;
        end else if (en) begin
            case (step_s)
                STEP_INC: cnt_next_s = cnt_r + CNT_ONE;
                STEP_DEC: cnt_next_s = cnt_r - CNT_ONE;
                default:  cnt_next_s = cnt_r;
            endcase
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Next velocity accumulator value, saturating symmetrically.
    always_comb begin
        acc_next_s = acc_r;
        if (en) begin
            case (step_s)
                STEP_INC: acc_next_s = (acc_r == VEL_MAX) ? acc_r : acc_r + VEL_ONE;
                STEP_DEC: acc_next_s = (acc_r == VEL_MIN) ? acc_r : acc_r - VEL_ONE;
                default:  acc_next_s = acc_r;
            endcase
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Decode history tracks the filter even while disabled so re-enabling causes no step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= 2'b00;
            cnt_r   <= '0;
        end else begin
            state_r <= filt_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Window close publishes the accumulator (including this clock's step) and restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            vel_r <= '0;
        end else if (win_last) begin
            acc_r <= '0;
            vel_r <= acc_next_s;
        end else begin
            acc_r <= acc_next_s;
            vel_r <= vel_r;
        end
    end

    // Direction of the last legal step and sticky illegal-transition flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (en && (step_s == STEP_INC)) begin
                dir_r <= 1'b1;
            end else if (en && (step_s == STEP_DEC)) begin
                dir_r <= 1'b0;
            end else begin
                dir_r <= dir_r;
            end
            if (en && (step_s == STEP_ERR)) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign cnt_next = cnt_next_s;
    assign cnt      = cnt_r;
    assign vel      = vel_r;
    assign dir      = dir_r;
    assign err      = err_r;

endmodule

// File: rtl/qei_array.sv
// N-channel quadrature encoder interface: per-channel decoders plus a shared
// velocity window and a coherent snapshot of all positions.
import qei_array_pkg::*;

module qei_array #(
    parameter int NCH         = 2,
    parameter int NBITS       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int VEL_PERIOD  = 1000,
    parameter int VBITS       = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       a_i,
    input  logic [NCH-1:0]       b_i,
    input  logic                 snap,
    input  logic                 err_clr,
    output logic [NCH*NBITS-1:0] cnt_o,
    output logic [NCH*NBITS-1:0] snap_o,
    output logic [NCH*VBITS-1:0] vel_o,
    output logic                 vel_valid,
    output logic [NCH-1:0]       dir_o,
    output logic [NCH-1:0]       err_o
);

    localparam int WW = $clog2(VEL_PERIOD);
    localparam logic [WW-1:0] WIN_LAST = WW'(VEL_PERIOD - 1);
    localparam logic [WW-1:0] WIN_ONE  = WW'(1);

    logic [WW-1:0]        win_cnt_r;
    logic                 win_last_s;
    logic                 vel_valid_r;
    logic [NCH*NBITS-1:0] cnt_next_all_s;
    logic [NCH*NBITS-1:0] snap_r;

    assign win_last_s = (win_cnt_r == WIN_LAST);

    // Free-running velocity window counter, independent of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_r <= '0;
        end else if (win_last_s) begin
            win_cnt_r <= '0;
        end else begin
            win_cnt_r <= win_cnt_r + WIN_ONE;
        end
    end

    // Flag the clock on which the new velocity values become visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            vel_valid_r <= 1'b0;
        end else begin
            vel_valid_r <= win_last_s;
        end
    end

    // Capture every channel's post-update position on the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_r <= '0;
        end else if (snap) begin
            snap_r <= cnt_next_all_s;
        end else begin
            snap_r <= snap_r;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        qei_array_chan #(
            .NBITS      (NBITS),
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN),
            .VBITS      (VBITS)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clr     (clr[k]),
            .a       (a_i[k]),
            .b       (b_i[k]),
            .err_clr (err_clr),
            .win_last(win_last_s),
            .cnt_next(cnt_next_all_s[k*NBITS +: NBITS]),
            .cnt     (cnt_o[k*NBITS +: NBITS]),
            .vel     (vel_o[k*VBITS +: VBITS]),
            .dir     (dir_o[k]),
            .err     (err_o[k])
        );
    end

    assign vel_valid = vel_valid_r;
    assign snap_o    = snap_r;

endmodule
